wired_cdb_arbiter: RTL and testbench
====================================

// Module: wired_cdb_arbiter
// PURPOSE
//  Shares the two CDB broadcast ports between the four result producers (ALU0, ALU1, LSU, MDU).
//  Fixed priority ALU0 > ALU1 > LSU > MDU, with an aging override so LSU/MDU cannot starve.
//  Output port b carries only results whose ROB bank (rob_id[0]) equals b, so ROB bank writes never conflict.
//  Sits between the FU issue queues (cdb_payload_o/cdb_valid_o/cdb_ready_i) and every CDB snoop port.
// PARAMETERS
//  N_REQ         4    requesters; index 0 = highest fixed priority
//  STARVE_LIMIT  8    consecutive denied cycles before a requester is promoted
//  CNT_W         $clog2(STARVE_LIMIT+1)   aging counter width (derived, not overridden)
// PORTS
//  clk           in   1                     clock
//  rst_n         in   1                     synchronous reset, active low
//  req_payload_i in   N_REQ x pipeline_cdb_t   result from each FU
//  req_valid_i   in   N_REQ                 result present
//  req_ready_o   out  N_REQ                 result accepted this cycle (combinational grant)
//  cdb_o         out  2 x pipeline_cdb_data_t  broadcast data, index = ROB bank
//  cdb_valid_o   out  2                     broadcast valid per bank
//  flush_i       in   1                     backend flush
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): cdb_valid_o=0, cdb_o=0, all aging counters=0. req_ready_o is forced to 0 while rst_n=0.
//  - Handshake: transfer on req_valid_i[i] & req_ready_o[i]. req_ready_o may depend combinationally on req_valid_i and payload.
//    Requesters hold the payload stable until accepted. The CDB never back-pressures.
//  - Per bank b: eligible = req_valid_i[i] & (req_payload_i[i].rob_id[0]==b).
//    Winner = lowest-index eligible requester with cnt==STARVE_LIMIT; else lowest-index eligible requester.
//    At most one grant per bank per cycle. Up to two grants per cycle total, one per bank.
//  - Latency: 1 cycle. The payload granted in cycle t appears on cdb_o[b] with cdb_valid_o[b]=1 in cycle t+1.
//    When bank b has no grant in cycle t, cdb_valid_o[b]=0 in t+1; cdb_o[b] is don't-care (hold last value).
//  - Aging counter per requester:
//    * +1 (saturating at STARVE_LIMIT) when valid and not granted.
//    * Cleared to 0 on grant, or when req_valid_i drops.
//  - Flush: while flush_i=1, req_ready_o = req_valid_i (drain everything).
//    cdb_valid_o = 0 in the following cycle; all counters are cleared.
//    A flush cycle overrides any normal grant.
//  - Simultaneous events: two requesters in the same bank -> one is granted, the loser ages.
//    Two requesters in different banks -> both are granted.
//  - Reset mid-operation: in-flight registered results are discarded; no partial state survives.
// STRUCTURE
//  - pipeline_cdb_t, pipeline_cdb_data_t and the rob_id field layout come from the shared wired0 package.
//  - Add to that package: requester index constants (CDB_REQ_ALU0=0, ALU1=1, LSU=2, MDU=3) and N_CDB_BANK=2.
//  - One sub-module, wired_cdb_bank_pick: combinational priority picker with starvation override.
//    Inputs: eligible mask and starved mask. Outputs: one-hot grant and valid. Instantiated once per bank.
//  - The top level holds the aging counters, the output registers and the conversion cdb_t -> cdb_data_t.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with all req_valid_i=1 -> req_ready_o=0000, cdb_valid_o=00.
//     After release, the first grants appear.
//  2. ALU0 rob_id=4 and ALU1 rob_id=7 valid in cycle t -> req_ready_o=0011;
//     at t+1 cdb_valid_o=11, cdb_o[0].rob_id=4, cdb_o[1].rob_id=7.
//  3. Bank conflict: ALU0 and LSU both with rob_id even -> ALU0 granted, LSU ready=0;
//     LSU is granted the next cycle once ALU0 deasserts.
//  4. Starvation: ALU0 continuously valid in bank 0, MDU valid in bank 0 ->
//     MDU is denied 8 cycles, then granted on the 9th, with ALU0 denied that cycle.
//  5. Flush: all 4 valid, flush_i=1 for 1 cycle -> req_ready_o=1111, cdb_valid_o=00 next cycle, counters read 0.
//  6. Random: valid/bank traffic for 10k cycles, checked by a scoreboard. Required properties:
//     every accepted result is broadcast exactly once (outside flush); ≤1 grant per bank per cycle;
//     no requester waits more than STARVE_LIMIT+N_REQ cycles.

Source files
------------

// File: rtl/wired_cdb_arbiter_pkg.sv
// Shared CDB types, requester indices and the producer-to-broadcast conversion.
package wired_cdb_arbiter_pkg;

  localparam int unsigned ROB_ID_W   = 6;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned EXC_CODE_W = 4;

  // rob_id[ROB_BANK_BIT] selects the ROB bank and therefore the CDB port.
  localparam int unsigned ROB_BANK_BIT = 0;

  localparam int unsigned N_CDB_BANK = 2;

  // Requester indices; a lower index means higher fixed priority.
  localparam int unsigned CDB_REQ_ALU0 = 0;
  localparam int unsigned CDB_REQ_ALU1 = 1;
  localparam int unsigned CDB_REQ_LSU  = 2;
  localparam int unsigned CDB_REQ_MDU  = 3;

  // Result as produced by a functional unit.
  typedef struct packed {
    logic [ROB_ID_W-1:0]   rob_id;
    logic [XLEN-1:0]       result;
    logic                  exc_valid;
    logic [EXC_CODE_W-1:0] exc_code;
  } pipeline_cdb_t;

  // Result as broadcast to the snoop ports.
  typedef struct packed {
    logic [ROB_ID_W-1:0]   rob_id;
    logic [XLEN-1:0]       data;
    logic                  exc;
    logic [EXC_CODE_W-1:0] cause;
  } pipeline_cdb_data_t;

  // The cause is zeroed when no exception is raised, so snoopers can use it unqualified.
  function automatic pipeline_cdb_data_t cdb_to_data(input pipeline_cdb_t c);
    pipeline_cdb_data_t d;
    d.rob_id = c.rob_id;
    d.data   = c.result;
    d.exc    = c.exc_valid;
    d.cause  = c.exc_valid ? c.exc_code : '0;
    return d;
  endfunction

endpackage

// File: rtl/wired_cdb_bank_pick.sv
// Combinational priority picker for one CDB bank: starved requesters first, then fixed priority.
module wired_cdb_bank_pick
  import wired_cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [N_REQ-1:0] starved_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] aged;
  logic [N_REQ-1:0] pool;

  // Pick the lowest-index bit of the starved pool if any, else of the eligible set.
  always_comb begin
    aged    = elig_i & starved_i;
    pool    = (|aged) ? aged : elig_i;
    gnt_o   = pool & (~pool + N_REQ'(1));
    valid_o = |elig_i;
  end

endmodule

// File: rtl/wired_cdb_arbiter.sv
// Arbitrates four result producers onto two ROB-banked CDB ports with starvation aging.
module wired_cdb_arbiter
  import wired_cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  pipeline_cdb_t      [N_REQ-1:0]        req_payload_i,
  input  logic               [N_REQ-1:0]        req_valid_i,
  output logic               [N_REQ-1:0]        req_ready_o,
  output pipeline_cdb_data_t [N_CDB_BANK-1:0]   cdb_o,
  output logic               [N_CDB_BANK-1:0]   cdb_valid_o,
  input  logic                                  flush_i
);

  logic [N_CDB_BANK-1:0][N_REQ-1:0] elig;
  logic [N_CDB_BANK-1:0][N_REQ-1:0] bank_gnt;
  logic [N_CDB_BANK-1:0]            bank_vld;
  logic [N_REQ-1:0]                 starved;
  logic [N_REQ-1:0]                 gnt_any;
  logic [N_REQ-1:0][CNT_W-1:0]      cnt_q, cnt_d;

  pipeline_cdb_t      [N_CDB_BANK-1:0] win_payload;
  pipeline_cdb_data_t [N_CDB_BANK-1:0] cdb_q, cdb_d;
  logic               [N_CDB_BANK-1:0] cdb_valid_q, cdb_valid_d;

  // Sort valid requests into banks by ROB bank bit and flag saturated aging counters.
  always_comb begin
    elig    = '0;
    starved = '0;
    for (int i = 0; i < N_REQ; i++) begin
      starved[i] = (cnt_q[i] == CNT_W'(STARVE_LIMIT));
      for (int b = 0; b < N_CDB_BANK; b++) begin
        elig[b][i] = req_valid_i[i] & (req_payload_i[i].rob_id[ROB_BANK_BIT] == 1'(b));
      end
    end
  end

  for (genvar b = 0; b < N_CDB_BANK; b++) begin : g_bank
    wired_cdb_bank_pick #(
      .N_REQ(N_REQ)
    ) u_pick (
      .elig_i   (elig[b]),
      .starved_i(starved),
      .gnt_o    (bank_gnt[b]),
      .valid_o  (bank_vld[b])
    );
  end

  // Merge bank grants into the ready vector; flush drains everything, reset accepts nothing.
  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < N_CDB_BANK; b++) begin
      gnt_any = gnt_any | bank_gnt[b];
    end
    if (!rst_n) begin
      req_ready_o = '0;
    end else if (flush_i) begin
      req_ready_o = req_valid_i;
    end else begin
      req_ready_o = gnt_any;
    end
  end

  // Aging: count denied cycles while valid, saturating; clear on grant, drop or flush.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (flush_i || !req_valid_i[i] || gnt_any[i]) begin
        cnt_d[i] = '0;
      end else if (!starved[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Select each bank winner's payload; the data register holds when the bank is idle.
  always_comb begin
    win_payload = '0;
    cdb_d       = cdb_q;
    cdb_valid_d = '0;
    for (int b = 0; b < N_CDB_BANK; b++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bank_gnt[b][i]) begin
          win_payload[b] = req_payload_i[i];
        end
      end
      cdb_valid_d[b] = bank_vld[b] & ~flush_i;
      if (cdb_valid_d[b]) begin
        cdb_d[b] = cdb_to_data(win_payload[b]);
      end
    end
  end

  // State registers; reset discards any in-flight broadcast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cdb_q       <= '0;
      cdb_valid_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
    end
  end

  assign cdb_o       = cdb_q;
  assign cdb_valid_o = cdb_valid_q;

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Scoreboard bench for wired_cdb_arbiter: directed scenarios followed by random traffic.
module tb_wired_cdb_arbiter;
  import wired_cdb_arbiter_pkg::*;

  localparam int NReq  = 4;
  localparam int Limit = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  pipeline_cdb_t      [NReq-1:0] pay;
  logic               [NReq-1:0] vld;
  logic               [NReq-1:0] rdy;
  pipeline_cdb_data_t [1:0]      cdb;
  logic               [1:0]      cdb_vld;

  always #5 clk = ~clk;

  wired_cdb_arbiter #(
    .N_REQ       (NReq),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_payload_i(pay),
    .req_valid_i  (vld),
    .req_ready_o  (rdy),
    .cdb_o        (cdb),
    .cdb_valid_o  (cdb_vld),
    .flush_i      (flush)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                 due;
    pipeline_cdb_data_t data;
  } exp_t;

  exp_t           sbq[2][$];
  int             age[NReq];
  int             waitc[NReq];
  logic [NReq-1:0] acc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic pipeline_cdb_data_t exp_data(input pipeline_cdb_t p);
    pipeline_cdb_data_t d;
    d.rob_id = p.rob_id;
    d.data   = p.result;
    d.exc    = p.exc_valid;
    d.cause  = p.exc_valid ? p.exc_code : 4'h0;
    return d;
  endfunction

  // Reference model: decides grants from the arbitration rules and queues expected broadcasts.
  always @(negedge clk) begin
    logic [NReq-1:0] exp_rdy;
    exp_rdy = '0;
    if (!rst_n) begin
      exp_rdy = '0;
    end else if (flush) begin
      exp_rdy = vld;
    end else begin
      for (int b = 0; b < 2; b++) begin
        int   win;
        exp_t e;
        win = -1;
        for (int i = 0; i < NReq; i++)
          if (win < 0 && vld[i] && int'(pay[i].rob_id[0]) == b && age[i] >= Limit) win = i;
        for (int i = 0; i < NReq; i++)
          if (win < 0 && vld[i] && int'(pay[i].rob_id[0]) == b) win = i;
        if (win >= 0) begin
          exp_rdy[win] = 1'b1;
          e.due  = cyc + 1;
          e.data = exp_data(pay[win]);
          sbq[b].push_back(e);
        end
      end
    end
    check("req_ready", rdy, exp_rdy);
    for (int i = 0; i < NReq; i++) begin
      if (rst_n && !flush && vld[i] && exp_rdy[i]) begin
        n_checks++;
        if (waitc[i] <= Limit + NReq) n_pass++;
        else $display("FAIL wait_bound req%0d: waited %0d cycles, limit %0d", i, waitc[i],
                      Limit + NReq);
      end
      if (!rst_n || flush || !vld[i] || exp_rdy[i]) age[i] = 0;
      else if (age[i] < Limit) age[i] = age[i] + 1;
      if (!rst_n || !vld[i] || exp_rdy[i]) waitc[i] = 0;
      else waitc[i] = waitc[i] + 1;
    end
    acc = exp_rdy & vld;
  end

  // Monitor: every cycle each bank either shows the next queued result or is idle.
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (sbq[b].size() > 0 && sbq[b][0].due == cyc) begin
        check($sformatf("cdb%0d_valid", b), 64'(cdb_vld[b]), 64'd1);
        check($sformatf("cdb%0d_data", b), 64'(cdb[b]), 64'(sbq[b][0].data));
        void'(sbq[b].pop_front());
      end else begin
        check($sformatf("cdb%0d_idle", b), 64'(cdb_vld[b]), 64'd0);
      end
    end
  end

  task automatic set_req(input int i, input bit v, input logic [5:0] rob);
    vld[i]           = v;
    pay[i].rob_id    = rob;
    pay[i].result    = $urandom;
    pay[i].exc_valid = 1'($urandom_range(0, 1));
    pay[i].exc_code  = 4'($urandom);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ALU0 hogs bank 0 while MDU waits there; MDU must win exactly on the ninth cycle.
  task automatic starve_run(input string tag, input bit chk_flush);
    for (int k = 0; k <= Limit; k++) begin
      @(negedge clk);
      if (chk_flush && k == 0) check({tag, "_cdb_valid_after_flush"}, 64'(cdb_vld), 64'd0);
      check($sformatf("%s_k%0d", tag, k), 64'(rdy), (k < Limit) ? 64'h1 : 64'h8);
      next_cycle();
      if (k < Limit) set_req(0, 1'b1, 6'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    vld   = '0;
    pay   = '0;
    for (int i = 0; i < NReq; i++) begin
      age[i]   = 0;
      waitc[i] = 0;
    end

    // Reset held two cycles with every requester valid.
    set_req(0, 1'b1, 6'd0);
    set_req(1, 1'b1, 6'd2);
    set_req(2, 1'b1, 6'd1);
    set_req(3, 1'b1, 6'd3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_ready", 64'(rdy), 64'h0);
      check("rst_cdb_valid", 64'(cdb_vld), 64'h0);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant", 64'(rdy), 64'h5);
    check("post_rst_cdb_valid", 64'(cdb_vld), 64'h0);
    next_cycle();
    vld = '0;
    @(negedge clk);
    check("first_bcast_valid", 64'(cdb_vld), 64'h3);

    // Two requesters in different banks are both granted.
    next_cycle();
    set_req(0, 1'b1, 6'd4);
    set_req(1, 1'b1, 6'd7);
    @(negedge clk);
    check("dual_bank_ready", 64'(rdy), 64'h3);
    next_cycle();
    vld = '0;
    @(negedge clk);
    check("dual_bank_valid", 64'(cdb_vld), 64'h3);
    check("dual_bank_rob0", 64'(cdb[0].rob_id), 64'd4);
    check("dual_bank_rob1", 64'(cdb[1].rob_id), 64'd7);

    // Same-bank conflict: ALU0 wins, LSU follows once ALU0 leaves.
    next_cycle();
    set_req(0, 1'b1, 6'd2);
    set_req(2, 1'b1, 6'd6);
    @(negedge clk);
    check("conflict_ready", 64'(rdy), 64'h1);
    next_cycle();
    vld[0] = 1'b0;
    @(negedge clk);
    check("conflict_lsu_ready", 64'(rdy), 64'h4);
    next_cycle();
    vld = '0;

    // Starvation override.
    next_cycle();
    set_req(0, 1'b1, 6'd0);
    set_req(3, 1'b1, 6'd8);
    starve_run("starve", 1'b0);
    vld = '0;

    // Partial aging, then a flush that must restart it from zero.
    next_cycle();
    set_req(0, 1'b1, 6'd0);
    set_req(3, 1'b1, 6'd10);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_req(0, 1'b1, 6'd0);
    end
    next_cycle();
    flush = 1'b1;
    set_req(0, 1'b1, 6'd0);
    set_req(1, 1'b1, 6'd3);
    set_req(2, 1'b1, 6'd5);
    @(negedge clk);
    check("flush_ready", 64'(rdy), 64'hf);
    next_cycle();
    flush = 1'b0;
    vld   = '0;
    set_req(0, 1'b1, 6'd0);
    set_req(3, 1'b1, 6'd12);
    starve_run("post_flush", 1'b1);
    vld = '0;

    // Random traffic; requesters hold payloads until accepted.
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      if (c == 5000) rst_n = 1'b0;
      if (c == 5002) rst_n = 1'b1;
      flush = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NReq; i++) begin
        if (!vld[i] || acc[i]) begin
          if ($urandom_range(0, 3) != 0) set_req(i, 1'b1, 6'($urandom));
          else vld[i] = 1'b0;
        end
      end
    end

    next_cycle();
    vld   = '0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sbq[0].size() + sbq[1].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
